// File: rtl/load_wb_unit.sv
// Load/writeback unit: accepts one load at a time, reads the containing word
// from data memory, extracts and extends the addressed field, writes it back.
module load_wb_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [4:0]  ld_rd,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic [3:0]  web,
    output logic        ld_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a load transfers when ld_valid && ld_ready at posedge clk;
    // ld_ready is high only while idle, and the request is captured whole.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WB = 2'd2, ERR = 2'd3} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;
    logic        bad_req;
    logic        accept;
    logic [7:0]  byte_f;
    logic [15:0] half_f;
    logic [31:0] ext_data;

    assign accept = (state_q == IDLE) && ld_valid;

    always_comb begin
        bad_req = 1'b0;
        case (ld_size)
            2'b01:   bad_req = ld_addr[0];
            2'b10:   bad_req = (ld_addr[1:0] != 2'b00);
            2'b11:   bad_req = 1'b1;
            default: bad_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ld_valid) state_d = bad_req ? ERR : REQ;
            // A late ack on the final allowed cycle still wins over the timeout.
            REQ: begin
                if (mem_ack)                 state_d = WB;
                else if (cnt_q == CNT_LAST)  state_d = ERR;
            end
            WB:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_f = 8'h00;
        case (addr_q[1:0])
            2'b00:   byte_f = mem_rdata[7:0];
            2'b01:   byte_f = mem_rdata[15:8];
            2'b10:   byte_f = mem_rdata[23:16];
            default: byte_f = mem_rdata[31:24];
        endcase
        half_f = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ext_data = {{24{~uns_q & byte_f[7]}}, byte_f};
            2'b01:   ext_data = {{16{~uns_q & half_f[15]}}, half_f};
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= ld_addr;
                size_q <= ld_size;
                uns_q  <= ld_unsigned;
                rd_q   <= ld_rd;
                cnt_q  <= 8'd0;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == REQ && mem_ack) data_q <= ext_data;
        end
    end

    assign ld_ready  = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign we3       = (state_q == WB) && (rd_q != 5'd0);
    assign a3        = (state_q == WB) ? rd_q : 5'd0;
    assign wd3       = (state_q == WB) ? data_q : 32'd0;
    assign web       = (state_q == WB) ? 4'b1111 : 4'b0000;
    assign ld_err    = (state_q == ERR);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_load_wb_unit.sv
// Directed bench for load_wb_unit with a short timeout so the boundary and
// expiry behaviour can be exercised quickly.
module tb_load_wb_unit;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [4:0]  ld_rd;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [3:0]  web;
    logic        ld_err;
    logic [1:0]  dbg_state;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int we3_cnt = 0;
    int err_cnt = 0;
    logic [36:0] exp_q[$];

    load_wb_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_rd(ld_rd),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .we3(we3), .a3(a3), .wd3(wd3), .web(web),
        .ld_err(ld_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // scoreboard: every register write must match the next expected write
    always @(negedge clk) begin
        if (rst_n && ld_err) err_cnt++;
        if (rst_n && we3) begin
            we3_cnt++;
            if (exp_q.size() == 0) begin
                chk("we3_unexpected", 32'd1, 32'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("sb_a3", {27'd0, a3}, {27'd0, e[36:32]});
                chk("sb_wd3", wd3, e[31:0]);
                chk("sb_web", {28'd0, web}, 32'h0000000f);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [4:0] rd);
        ld_valid    = 1'b1;
        ld_addr     = addr;
        ld_size     = size;
        ld_unsigned = uns;
        ld_rd       = rd;
        tick();
        ld_valid    = 1'b0;
        ld_addr     = $urandom;
        ld_size     = 2'($urandom_range(0, 3));
        ld_unsigned = ~uns;
        ld_rd       = 5'($urandom_range(0, 31));
    endtask

    // leaves the bench in the WB cycle
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd,
                           input int wait_cycles, input logic [31:0] rdata);
        start_load(addr, size, uns, rd);
        chk("req_mem_addr", mem_addr, {addr[31:2], 2'b00});
        for (int i = 0; i < wait_cycles; i++) begin
            chk("req_mem_req", {31'd0, mem_req}, 32'd1);
            tick();
        end
        chk("req_mem_req_ack", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
    endtask

    initial begin
        int w0;
        rst_n = 1'b0; ld_valid = 1'b0; ld_addr = 32'd0; ld_size = 2'b00;
        ld_unsigned = 1'b0; ld_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #3;
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_outs", {we3, a3, web, ld_err}, 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        tick();
        rst_n = 1'b1;

        // word load, ack on the last allowed REQ cycle
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        do_load(32'h100, 2'b10, 1'b0, 5'd5, 3, 32'hDEADBEEF);
        chk("w_we3", {31'd0, we3}, 32'd1);
        chk("w_a3", {27'd0, a3}, 32'd5);
        chk("w_wd3", wd3, 32'hDEADBEEF);
        chk("w_ready_wb", {31'd0, ld_ready}, 32'd0);
        tick();
        chk("w_we3_off", {31'd0, we3}, 32'd0);
        chk("w_ready_back", {31'd0, ld_ready}, 32'd1);
        chk("w_err", err_cnt, 0);

        exp_q.push_back({5'd7, 32'hFFFFFF80});
        do_load(32'h203, 2'b00, 1'b0, 5'd7, 0, 32'h80FF1234);
        chk("sb_wd3", wd3, 32'hFFFFFF80);
        tick();
        exp_q.push_back({5'd8, 32'h00000080});
        do_load(32'h203, 2'b00, 1'b1, 5'd8, 1, 32'h80FF1234);
        chk("ub_wd3", wd3, 32'h00000080);
        tick();
        exp_q.push_back({5'd9, 32'hFFFF9ABC});
        do_load(32'h302, 2'b01, 1'b0, 5'd9, 2, 32'h9ABC0000);
        chk("sh_wd3", wd3, 32'hFFFF9ABC);
        tick();
        exp_q.push_back({5'd10, 32'h00008001});
        do_load(32'h300, 2'b01, 1'b1, 5'd10, 0, 32'h12348001);
        chk("uh_wd3", wd3, 32'h00008001);
        tick();
        exp_q.push_back({5'd11, 32'h0000007F});
        do_load(32'h401, 2'b00, 1'b0, 5'd11, 0, 32'h00007F00);
        chk("sb1_wd3", wd3, 32'h0000007F);
        tick();

        // error requests: misaligned half, misaligned word, reserved size
        w0 = we3_cnt;
        start_load(32'h301, 2'b01, 1'b0, 5'd3);
        chk("mh_err", {31'd0, ld_err}, 32'd1);
        chk("mh_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("mh_err_off", {31'd0, ld_err}, 32'd0);
        chk("mh_ready", {31'd0, ld_ready}, 32'd1);
        start_load(32'h102, 2'b10, 1'b0, 5'd3);
        chk("mw_err", {31'd0, ld_err}, 32'd1);
        tick();
        start_load(32'h100, 2'b11, 1'b0, 5'd3);
        chk("rs_err", {31'd0, ld_err}, 32'd1);
        chk("rs_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("err_no_we3", we3_cnt, w0);
        chk("err_pulses", err_cnt, 3);

        // timeout: four REQ cycles, then one error cycle
        start_load(32'h500, 2'b10, 1'b0, 5'd12);
        for (int i = 0; i < 4; i++) begin
            chk("to_mem_req", {31'd0, mem_req}, 32'd1);
            tick();
        end
        chk("to_err", {31'd0, ld_err}, 32'd1);
        chk("to_mem_req_off", {31'd0, mem_req}, 32'd0);
        tick();
        chk("to_ready", {31'd0, ld_ready}, 32'd1);
        chk("to_no_we3", we3_cnt, w0);

        // ack while idle is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_state", {30'd0, dbg_state}, 32'd0);

        // rd = 0: memory access happens, no write, no error
        do_load(32'h600, 2'b10, 1'b0, 5'd0, 1, 32'h55AA55AA);
        chk("rd0_we3", {31'd0, we3}, 32'd0);
        chk("rd0_err", {31'd0, ld_err}, 32'd0);
        tick();
        chk("rd0_no_we3", we3_cnt, w0);

        // reset in the middle of REQ
        start_load(32'h700, 2'b10, 1'b0, 5'd13);
        chk("mr_mem_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req_drop", {31'd0, mem_req}, 32'd0);
        chk("mr_ready", {31'd0, ld_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        exp_q.push_back({5'd14, 32'h11223344});
        do_load(32'h704, 2'b10, 1'b0, 5'd14, 0, 32'h11223344);
        chk("mr_next_we3", {31'd0, we3}, 32'd1);
        tick();

        chk("sb_empty", exp_q.size(), 0);
        chk("we3_total", we3_cnt, 7);
        chk("err_total", err_cnt, 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
